// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment driver.
// The scan clock is a plain data input, synchronised into the clk domain and
// edge-detected. Each rising edge advances the active digit. The displayed value
// is captured once per full scan, on the 3->0 wrap, so a frame never shows
// digits taken from two different input values.
module seg7_scan #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // "Off" encodings for the chosen polarities
  localparam logic [3:0] AN_OFF  = {4{AN_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic        r_s1, r_s2, r_s3;
  logic        w_step;
  logic [1:0]  r_idx;
  logic [15:0] r_val;
  logic [3:0]  r_dp;
  logic        r_blank;
  logic [3:0]  w_nib;
  logic [6:0]  w_hex;
  logic        w_blank;
  logic [3:0]  w_an_hi;
  logic [6:0]  w_seg_hi;
  logic        w_dp_hi;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp_o;

  // Two-flop synchroniser plus one extra stage for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= scan_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_step = r_s2 & ~r_s3;

  // Digit index advance; the inputs are captured on the wrap to digit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= 2'd0;
      r_val   <= 16'h0000;
      r_dp    <= 4'h0;
      r_blank <= 1'b0;
    end else if (w_step) begin
      r_idx <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_val   <= value;
        r_dp    <= dp_in;
        r_blank <= blank_lz;
      end
    end
  end

  // Hex decode, leading-zero blanking and one-hot digit select (active-high form)
  always_comb begin
    w_nib = r_val[{r_idx, 2'b00} +: 4];
    w_hex = 7'h00;
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase
    w_blank = 1'b0;
    case (r_idx)
      2'd3: w_blank = (r_val[15:12] == 4'h0);
      2'd2: w_blank = (r_val[15:8]  == 8'h00);
      2'd1: w_blank = (r_val[15:4]  == 12'h000);
      default: w_blank = 1'b0;
    endcase
    w_blank  = w_blank & r_blank;
    w_seg_hi = w_blank ? 7'h00 : w_hex;
    w_an_hi  = 4'b0001 << r_idx;
    w_dp_hi  = r_dp[r_idx];
  end

  // Registered outputs with polarity applied; reset forces everything dark
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an   <= AN_OFF;
      r_seg  <= SEG_OFF;
      r_dp_o <= DP_OFF;
    end else begin
      r_an   <= w_an_hi  ^ AN_OFF;
      r_seg  <= w_seg_hi ^ SEG_OFF;
      r_dp_o <= w_dp_hi  ^ DP_OFF;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp_o;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (default active-low polarities).
// Stimulus pushes expected {an,seg,dp} tagged with the clk cycle they belong to;
// a monitor on the falling edge pops and compares them independently.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that belongs to the current cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || an !== e.an || seg !== e.seg || dp !== e.dp) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 e.nm, cyc, e.cyc, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string nm, input logic [3:0] a,
                            input logic [6:0] s, input logic d);
    exp_t e;
    e.cyc = cyc; e.an = a; e.seg = s; e.dp = d; e.nm = nm;
    q.push_back(e);
  endtask

  // One full scan edge: settle low, then rise and wait until outputs reflect it (E4)
  task automatic scan_edge();
    scan_clk = 1'b0;
    tick(3);
    scan_clk = 1'b1;
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; scan_clk = 1'b0; value = 16'h0000; dp_in = 4'h0; blank_lz = 1'b0;
    tick(2);
    expect_out("reset", 4'b1111, 7'h7F, 1'b1);

    reset = 1'b0;
    tick(1);
    expect_out("post_reset", 4'b1110, 7'h40, 1'b1);
    tick(3);
    expect_out("idle_no_edges", 4'b1110, 7'h40, 1'b1);

    // Latency: rise sampled at E1, idx moves at E3, outputs at E4
    scan_clk = 1'b1;
    tick(1); expect_out("lat_E1", 4'b1110, 7'h40, 1'b1);
    tick(1); expect_out("lat_E2", 4'b1110, 7'h40, 1'b1);
    tick(1); expect_out("lat_E3", 4'b1110, 7'h40, 1'b1);
    tick(1); expect_out("lat_E4", 4'b1101, 7'h40, 1'b1);
    tick(50); expect_out("hold_high", 4'b1101, 7'h40, 1'b1);

    // Full scan of 12AF (idx is 1; three edges reach the wrap)
    value = 16'h12AF; dp_in = 4'h0; blank_lz = 1'b0;
    scan_edge(); expect_out("pre_d2_old", 4'b1011, 7'h40, 1'b1);
    scan_edge(); expect_out("pre_d3_old", 4'b0111, 7'h40, 1'b1);
    scan_edge(); expect_out("scan_d0_F", 4'b1110, 7'h0E, 1'b1);
    scan_edge(); expect_out("scan_d1_A", 4'b1101, 7'h08, 1'b1);
    scan_edge(); expect_out("scan_d2_2", 4'b1011, 7'h24, 1'b1);
    scan_edge(); expect_out("scan_d3_1", 4'b0111, 7'h79, 1'b1);

    // Leading-zero blanking of 0050
    value = 16'h0050; blank_lz = 1'b1;
    scan_edge(); expect_out("blz_d0", 4'b1110, 7'h40, 1'b1);
    scan_edge(); expect_out("blz_d1", 4'b1101, 7'h12, 1'b1);
    scan_edge(); expect_out("blz_d2", 4'b1011, 7'h7F, 1'b1);
    scan_edge(); expect_out("blz_d3", 4'b0111, 7'h7F, 1'b1);
    value = 16'h0000;
    scan_edge(); expect_out("zero_d0", 4'b1110, 7'h40, 1'b1);
    scan_edge(); expect_out("zero_d1", 4'b1101, 7'h7F, 1'b1);
    scan_edge(); expect_out("zero_d2", 4'b1011, 7'h7F, 1'b1);
    scan_edge(); expect_out("zero_d3", 4'b0111, 7'h7F, 1'b1);

    // No tearing: change value while idx=2
    value = 16'h1111; blank_lz = 1'b0;
    scan_edge(); expect_out("t1_d0", 4'b1110, 7'h79, 1'b1);
    scan_edge(); expect_out("t1_d1", 4'b1101, 7'h79, 1'b1);
    scan_edge(); expect_out("t1_d2", 4'b1011, 7'h79, 1'b1);
    value = 16'h2222;
    scan_edge(); expect_out("t1_d3_old", 4'b0111, 7'h79, 1'b1);
    scan_edge(); expect_out("t2_d0", 4'b1110, 7'h24, 1'b1);
    scan_edge(); expect_out("t2_d1", 4'b1101, 7'h24, 1'b1);
    scan_edge(); expect_out("t2_d2", 4'b1011, 7'h24, 1'b1);
    scan_edge(); expect_out("t2_d3", 4'b0111, 7'h24, 1'b1);

    // Reset mid-scan at idx=3
    dp_in = 4'b1000;
    scan_clk = 1'b0;
    reset = 1'b1;
    tick(1); expect_out("midrst", 4'b1111, 7'h7F, 1'b1);
    tick(1);
    reset = 1'b0;
    tick(1); expect_out("midrst_rel", 4'b1110, 7'h40, 1'b1);

    // Decimal point path after restart: four edges to wrap, dp on digit0
    dp_in = 4'b0001;
    scan_edge(); expect_out("rs_d1", 4'b1101, 7'h40, 1'b1);
    scan_edge();
    scan_edge();
    scan_edge(); expect_out("dp_d0", 4'b1110, 7'h24, 1'b0);
    scan_edge(); expect_out("dp_d1", 4'b1101, 7'h24, 1'b1);

    tick(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
